aes_128_dec_iter: RTL
=====================

Name: aes_128_dec_iter

Overview:
- Iterative AES-128 decryption core (FIPS-197 inverse cipher); the receive-side counterpart of the pipelined aes_128 encryptor.
- Accepts one ciphertext/key pair through a valid/ready handshake.
- Expands the key forward to round key 10, then runs 10 inverse rounds, one per cycle, regenerating round keys backward on the fly.
- Sits between the link receive buffer and the plaintext consumer.

Parameters:
- NR, 10, number of rounds; fixed for AES-128, the only legal value.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  ciphertext and key are valid.
- in_ready  out  1  core can accept; high only in IDLE.
- state  in  128  ciphertext, byte 0 at [127:120].
- key  in  128  cipher key, same byte order.
- out  out  128  plaintext; held stable while out_valid is high.
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer accepts out.

Behaviour:
- Reset values: in_ready=0 during the reset cycle, then 1 in IDLE. out=0, out_valid=0. FSM=IDLE. Round counter=0.
- FSM IDLE: in_valid&&in_ready at edge E0 registers state into s and key into rk; go to KEYEXP with cnt=1.
- FSM KEYEXP, edges E1..E10: rk <= fwd_expand(rk, rcon[cnt]); cnt++.
  - At E10, also s <= s ^ fwd_expand(rk, rcon[10]) (AddRoundKey with rk10); go to ROUND with cnt=9.
- FSM ROUND, edges E11..E20: t = InvSubBytes(InvShiftRows(s)) ^ prev_rk, where prev_rk = inv_expand(rk, rcon[cnt+1]) is round key cnt.
  - For cnt 9..1: s <= InvMixColumns(t).
  - For cnt 0: out <= t, out_valid <= 1, go to DONE.
  - rk <= prev_rk; cnt-- each edge.
- inv_expand(w0..w3, rc): w3' = w3^w2; w2' = w2^w1; w1' = w1^w0; w0' = w0^SubWord(RotWord(w3'))^{rc,24'h0}.
- FSM DONE: out and out_valid held until out_valid&&out_ready, then out_valid=0 and go to IDLE. in_ready stays 0 in DONE, so there is no same-edge accept.
- Latency: out_valid is observed high after edge E20, i.e. 20 clocks after the accept edge. Throughput is one block per 22 clocks minimum (accept, 20 busy edges, drain).
- in_valid is ignored outside IDLE. Input data is sampled only at E0; later changes have no effect.
- out_ready asserted outside DONE has no effect.
- reset asserted in any state at any cycle returns to reset values on that edge. A partial result is never presented.
- All arithmetic is GF(2^8) with modulus 0x11B. InvMixColumns uses coefficients {0e,0b,0d,09}.

Optional Feature:
- Macro: AES_DEC_KEY_CACHE_EN.
- When defined:
  - A 128-bit cached key, a 128-bit cached rk10 and a cache_vld flag (reset 0) are added.
  - Cache is written at E10 of every KEYEXP.
  - On accept with cache_vld && key==cached key: skip KEYEXP. At E0, s <= state ^ cached rk10, rk <= cached rk10, go directly to ROUND with cnt=9.
  - Cached-hit latency is 10 clocks.
- When undefined: no cache registers exist; latency is always 20.

Decomposition:
- Package aes_128_pkg holds:
  - functions sbox, inv_sbox (algebraic GF inverse plus affine transform, or 256-entry constant tables).
  - functions xtime, gmul, SubWord, RotWord.
  - constant array RCON[1:10] = 01,02,04,08,10,20,40,80,1b,36.
  - FSM state typedef {IDLE, KEYEXP, ROUND, DONE}.
- One combinational sub-module, aes_128_inv_round: inputs s, rk, final flag; output next s. It does InvShiftRows → InvSubBytes → AddRoundKey → optional InvMixColumns.
- Key-schedule logic stays in the top level.

Test Plan:
- FIPS vector A: state=3925841d02dc09fbdc118597196a0b32, key=2b7e151628aed2a6abf7158809cf4f3c → out=3243f6a8885a308d313198a2e0370734, out_valid exactly 20 clocks after accept.
- FIPS vector C.1: state=69c4e0d86a7b0430d8cdb78070b4c55a, key=000102030405060708090a0b0c0d0e0f → out=00112233445566778899aabbccddeeff.
- All-zero key: state=66e94bd4ef8a2c3b884cfa59ca342b2e, key=0 → out=0. Hold out_ready=0 for 15 clocks; out and out_valid must stay stable and in_ready must stay 0.
- Back-to-back: in_valid held high continuously with vectors A and C.1 → second accept occurs exactly 1 clock after the out handshake; in_valid pulses during busy cycles are ignored.
- Reset mid-op: assert reset at E7 of vector A → next cycle out_valid=0, out=0, in_ready=1. A fresh vector A then decrypts correctly in 20 clocks.
- With AES_DEC_KEY_CACHE_EN: vector A twice with the same key → first latency 20, second latency 10, both out=3243f6a8885a308d313198a2e0370734. Changing the key restores latency 20.

Source files
------------

// File: rtl/aes_128_pkg.sv
// Shared AES-128 helpers for the iterative decryption core: GF(2^8)
// arithmetic, S-box / inverse S-box, word helpers, key-schedule steps
// in both directions, round constants and the controller state type.
package aes_128_pkg;

  localparam int NR = 10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } dec_state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] a;
    a = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round constant lookup; indices outside 1..10 yield zero.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    if ((idx >= 4'd1) && (idx <= 4'd10)) begin
      return RCON[idx];
    end else begin
      return 8'h00;
    end
  endfunction

  // One forward key-schedule step: round key i -> round key i+1.
  function automatic logic [127:0] fwd_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rc, 24'h000000};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // One backward key-schedule step: round key i+1 -> round key i.
  function automatic logic [127:0] inv_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_128_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the last round.
module aes_128_inv_round
  import aes_128_pkg::*;
(
  input  logic [127:0] s_i,
  input  logic [127:0] rk_i,
  input  logic         final_i,
  output logic [127:0] s_o
);

  logic [127:0] isr_s;
  logic [127:0] t_s;
  logic [127:0] imc_s;

  // Row r of column c takes the byte from column c-r (byte 0 at MSB).
  always_comb begin
    isr_s = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr_s[8*(15-(4*c+r)) +: 8] = s_i[8*(15-(4*((c+4-r)%4)+r)) +: 8];
      end
    end
  end

  // Inverse substitution followed by the round key.
  always_comb begin
    t_s = '0;
    for (int b = 0; b < 16; b++) begin
      t_s[8*b +: 8] = inv_sbox(isr_s[8*b +: 8]) ^ rk_i[8*b +: 8];
    end
  end

  // Column mix with the {0e,0b,0d,09} circulant.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    imc_s = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = t_s[8*(15-4*c)   +: 8];
      a1 = t_s[8*(14-4*c)   +: 8];
      a2 = t_s[8*(13-4*c)   +: 8];
      a3 = t_s[8*(12-4*c)   +: 8];
      imc_s[8*(15-4*c) +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      imc_s[8*(14-4*c) +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      imc_s[8*(13-4*c) +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      imc_s[8*(12-4*c) +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
  end

  // The last round skips the column mix.
  always_comb begin
    if (final_i) begin
      s_o = t_s;
    end else begin
      s_o = imc_s;
    end
  end

endmodule

// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 decryption core. One ciphertext/key pair is accepted
// in IDLE; the key is expanded forward to round key 10 (one step per clock),
// then ten inverse rounds run one per clock while round keys are regenerated
// backward. The plaintext is held in DONE until the consumer takes it.
// Optional build macro AES_DEC_KEY_CACHE_EN keeps the last key and its round
// key 10 so a repeated key skips the forward expansion.
module aes_128_dec_iter
  import aes_128_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic [127:0] out,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  dec_state_e   fsm_q;
  logic [3:0]   cnt_q;
  logic [127:0] s_q;
  logic [127:0] rk_q;
  logic [127:0] out_q;
  logic         out_valid_q;
  logic         in_ready_q;

  logic [127:0] rk_fwd_d;
  logic [127:0] rk_prev_d;
  logic [127:0] s_round_d;
  logic         accept;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] key_q;
  logic [127:0] cache_key_q;
  logic [127:0] cache_rk10_q;
  logic         cache_vld_q;
  logic         cache_hit;

  assign cache_hit = cache_vld_q && (key == cache_key_q);
`endif

  // rk_fwd_d is round key cnt when rk_q holds round key cnt-1;
  // rk_prev_d is round key cnt when rk_q holds round key cnt+1.
  assign rk_fwd_d  = fwd_expand(rk_q, rcon(cnt_q));
  assign rk_prev_d = inv_expand(rk_q, rcon(cnt_q + 4'd1));

  aes_128_inv_round u_inv_round (
    .s_i     (s_q),
    .rk_i    (rk_prev_d),
    .final_i (cnt_q == 4'd0),
    .s_o     (s_round_d)
  );

  // Ready is suppressed while reset is asserted so nothing is taken then.
  assign in_ready  = in_ready_q && !reset;
  assign accept    = in_valid && in_ready;
  assign out       = out_q;
  assign out_valid = out_valid_q;

  // Controller: accept, forward key expansion, inverse rounds, output hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= IDLE;
      cnt_q       <= 4'd0;
      s_q         <= 128'd0;
      rk_q        <= 128'd0;
      out_q       <= 128'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
      key_q        <= 128'd0;
      cache_key_q  <= 128'd0;
      cache_rk10_q <= 128'd0;
      cache_vld_q  <= 1'b0;
`endif
    end else begin
      case (fsm_q)
        IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
            if (cache_hit) begin
              s_q   <= state ^ cache_rk10_q;
              rk_q  <= cache_rk10_q;
              cnt_q <= 4'd9;
              fsm_q <= ROUND;
            end else begin
              s_q   <= state;
              rk_q  <= key;
              key_q <= key;
              cnt_q <= 4'd1;
              fsm_q <= KEYEXP;
            end
`else
            s_q   <= state;
            rk_q  <= key;
            cnt_q <= 4'd1;
            fsm_q <= KEYEXP;
`endif
          end
        end
        KEYEXP: begin
          rk_q <= rk_fwd_d;
          if (cnt_q == LAST_RND) begin
            s_q   <= s_q ^ rk_fwd_d;
            cnt_q <= 4'd9;
            fsm_q <= ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_key_q  <= key_q;
            cache_rk10_q <= rk_fwd_d;
            cache_vld_q  <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ROUND: begin
          rk_q <= rk_prev_d;
          if (cnt_q == 4'd0) begin
            out_q       <= s_round_d;
            out_valid_q <= 1'b1;
            fsm_q       <= DONE;
          end else begin
            s_q   <= s_round_d;
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          cnt_q       <= 4'd0;
          fsm_q       <= IDLE;
        end
      endcase
    end
  end

endmodule
